exe_mem_skid: RTL and testbench

- Pipeline boundary between the EXE stage (ALU/functional-unit result select) and the MEM stage.
- Registers the selected EXE result (Rd data/addr/write-enable, pc) behind a valid/ready handshake.
- A 2-entry skid buffer gives a registered, fully decoupled ready to EXE.
- Provides a combinational forwarding lookup so decode can bypass results still held in this stage.

---
 rtl/exe_mem_skid.sv | 189 ++++++++++++++++++
 tb/tb_exe_mem_skid.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_mem_skid.sv
// EXE->MEM pipeline boundary: 2-entry skid buffer with registered ready and a forwarding lookup.
// Optional macro EXE_MEM_STALL_CNT_EN adds stall_cnt_out, a saturating count of MEM back-pressure cycles.
module exe_mem_skid #(
   parameter int RSZ   = 32,
   parameter int PC_SZ = 32,
   parameter int RF_AW = 5
) (
   input  logic             clk_in,
   input  logic             reset_in,
   input  logic             flush_in,
   input  logic             exe_valid_in,
   output logic             exe_ready_out,
   input  logic [RSZ-1:0]   exe_rd_data_in,
   input  logic [RF_AW-1:0] exe_rd_addr_in,
   input  logic             exe_rd_wr_in,
   input  logic [PC_SZ-1:0] exe_pc_in,
   output logic             mem_valid_out,
   input  logic             mem_ready_in,
   output logic [RSZ-1:0]   mem_rd_data_out,
   output logic [RF_AW-1:0] mem_rd_addr_out,
   output logic             mem_rd_wr_out,
   output logic [PC_SZ-1:0] mem_pc_out,
   input  logic [RF_AW-1:0] fwd_addr_in,
   output logic             fwd_hit_out,
   output logic [RSZ-1:0]   fwd_data_out
`ifdef EXE_MEM_STALL_CNT_EN
   ,
   output logic [31:0]      stall_cnt_out
`endif
);

   // state    | meaning
   // ST_EMPTY | no entry held, ready to EXE
   // ST_ONE   | head entry H valid, ready to EXE
   // ST_TWO   | H and skid entry S valid, not ready
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic             ready_q;

   logic [RSZ-1:0]   h_data_q;
   logic [RF_AW-1:0] h_addr_q;
   logic             h_wr_q;
   logic [PC_SZ-1:0] h_pc_q;

   logic [RSZ-1:0]   s_data_q;
   logic [RF_AW-1:0] s_addr_q;
   logic             s_wr_q;
   logic [PC_SZ-1:0] s_pc_q;

   logic h_valid;
   logic s_valid;
   logic accept;
   logic retire;
   logic load_h_exe;
   logic load_h_skid;
   logic load_s;

   assign h_valid = (state_q == ST_ONE) || (state_q == ST_TWO);
   assign s_valid = (state_q == ST_TWO);
   assign accept  = exe_valid_in & ready_q;
   assign retire  = h_valid & mem_ready_in;

   always_comb begin
      state_d     = state_q;
      load_h_exe  = 1'b0;
      load_h_skid = 1'b0;
      load_s      = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d    = ST_ONE;
               load_h_exe = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept && retire) begin
               load_h_exe = 1'b1;
            end else if (accept) begin
               state_d = ST_TWO;
               load_s  = 1'b1;
            end else if (retire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (retire) begin
               state_d     = ST_ONE;
               load_h_skid = 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Flush wins over any same-cycle accept or skid shift; MEM still sees its retire.
      if (flush_in) begin
         state_d     = ST_EMPTY;
         load_h_exe  = 1'b0;
         load_h_skid = 1'b0;
         load_s      = 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q <= ST_EMPTY;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d != ST_TWO);
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         h_data_q <= '0;
         h_addr_q <= '0;
         h_wr_q   <= 1'b0;
         h_pc_q   <= '0;
         s_data_q <= '0;
         s_addr_q <= '0;
         s_wr_q   <= 1'b0;
         s_pc_q   <= '0;
      end else begin
         if (load_h_exe) begin
            h_data_q <= exe_rd_data_in;
            h_addr_q <= exe_rd_addr_in;
            h_wr_q   <= exe_rd_wr_in;
            h_pc_q   <= exe_pc_in;
         end else if (load_h_skid) begin
            h_data_q <= s_data_q;
            h_addr_q <= s_addr_q;
            h_wr_q   <= s_wr_q;
            h_pc_q   <= s_pc_q;
         end
         if (load_s) begin
            s_data_q <= exe_rd_data_in;
            s_addr_q <= exe_rd_addr_in;
            s_wr_q   <= exe_rd_wr_in;
            s_pc_q   <= exe_pc_in;
         end
      end
   end

   assign exe_ready_out = ready_q;
   assign mem_valid_out = h_valid;

   // Stale head fields are masked so MEM sees zeros whenever nothing is held.
   assign mem_rd_data_out = h_valid ? h_data_q : '0;
   assign mem_rd_addr_out = h_valid ? h_addr_q : '0;
   assign mem_rd_wr_out   = h_valid & h_wr_q;
   assign mem_pc_out      = h_valid ? h_pc_q : '0;

   logic fwd_nz;
   logic h_match;
   logic s_match;

   assign fwd_nz  = (fwd_addr_in != '0);
   assign h_match = h_valid & h_wr_q & (h_addr_q == fwd_addr_in) & fwd_nz;
   assign s_match = s_valid & s_wr_q & (s_addr_q == fwd_addr_in) & fwd_nz;

   // S is the younger entry, so it shadows H for the same register.
   always_comb begin
      fwd_hit_out  = s_match | h_match;
      fwd_data_out = '0;
      if (s_match) begin
         fwd_data_out = s_data_q;
      end else if (h_match) begin
         fwd_data_out = h_data_q;
      end
   end

`ifdef EXE_MEM_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         stall_cnt_q <= '0;
      end else if (h_valid && !mem_ready_in && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt_out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_exe_mem_skid.sv
// Bench for exe_mem_skid: directed scenarios plus randomized traffic against a queue model.
module tb_exe_mem_skid;
   localparam int RSZ   = 32;
   localparam int PC_SZ = 32;
   localparam int RF_AW = 5;

   logic             clk_in = 1'b0;
   logic             reset_in, flush_in, exe_valid_in, exe_ready_out;
   logic [RSZ-1:0]   exe_rd_data_in;
   logic [RF_AW-1:0] exe_rd_addr_in;
   logic             exe_rd_wr_in;
   logic [PC_SZ-1:0] exe_pc_in;
   logic             mem_valid_out, mem_ready_in;
   logic [RSZ-1:0]   mem_rd_data_out;
   logic [RF_AW-1:0] mem_rd_addr_out;
   logic             mem_rd_wr_out;
   logic [PC_SZ-1:0] mem_pc_out;
   logic [RF_AW-1:0] fwd_addr_in;
   logic             fwd_hit_out;
   logic [RSZ-1:0]   fwd_data_out;
`ifdef EXE_MEM_STALL_CNT_EN
   logic [31:0]      stall_cnt_out;
`endif

   exe_mem_skid #(.RSZ(RSZ), .PC_SZ(PC_SZ), .RF_AW(RF_AW)) dut (
      .clk_in(clk_in), .reset_in(reset_in), .flush_in(flush_in),
      .exe_valid_in(exe_valid_in), .exe_ready_out(exe_ready_out),
      .exe_rd_data_in(exe_rd_data_in), .exe_rd_addr_in(exe_rd_addr_in),
      .exe_rd_wr_in(exe_rd_wr_in), .exe_pc_in(exe_pc_in),
      .mem_valid_out(mem_valid_out), .mem_ready_in(mem_ready_in),
      .mem_rd_data_out(mem_rd_data_out), .mem_rd_addr_out(mem_rd_addr_out),
      .mem_rd_wr_out(mem_rd_wr_out), .mem_pc_out(mem_pc_out),
      .fwd_addr_in(fwd_addr_in), .fwd_hit_out(fwd_hit_out), .fwd_data_out(fwd_data_out)
`ifdef EXE_MEM_STALL_CNT_EN
      , .stall_cnt_out(stall_cnt_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [RSZ-1:0]   d;
      logic [RF_AW-1:0] a;
      logic             w;
      logic [PC_SZ-1:0] pc;
   } ent_t;

   ent_t        q[$];
   logic [31:0] stall_m = '0;
   int          checks = 0;
   int          failures = 0;

   // Reference: a FIFO of at most two entries; ready means fewer than two held.
   task automatic tick();
      int   n;
      ent_t e;
      @(posedge clk_in);
      n = q.size();
      e = '{d: exe_rd_data_in, a: exe_rd_addr_in, w: exe_rd_wr_in, pc: exe_pc_in};
      if (reset_in) stall_m = '0;
      else if (n > 0 && !mem_ready_in && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 1;
      if (reset_in || flush_in) begin
         q.delete();
      end else begin
         if (n > 0 && mem_ready_in) void'(q.pop_front());
         if (exe_valid_in && n < 2) q.push_back(e);
      end
      #1;
   endtask

   function automatic ent_t model_head();
      ent_t z;
      z = '0;
      if (q.size() > 0) z = q[0];
      return z;
   endfunction

   function automatic logic [RSZ:0] model_fwd(input logic [RF_AW-1:0] addr);
      for (int i = q.size() - 1; i >= 0; i--)
         if (q[i].w && q[i].a == addr && addr != '0) return {1'b1, q[i].d};
      return '0;
   endfunction

   task automatic offer(input logic v, input logic [RSZ-1:0] d, input logic [RF_AW-1:0] a,
                        input logic w, input logic [PC_SZ-1:0] pc);
      exe_valid_in   = v;
      exe_rd_data_in = d;
      exe_rd_addr_in = a;
      exe_rd_wr_in   = w;
      exe_pc_in      = pc;
   endtask

   task automatic do_reset();
      reset_in = 1'b1;
      flush_in = 1'b0;
      offer(1'b0, '0, '0, 1'b0, '0);
      tick();
      reset_in = 1'b0;
   endtask

   task automatic test_reset();
      reset_in = 1'b1;
      flush_in = 1'b0;
      mem_ready_in = 1'b0;
      fwd_addr_in = 5'd3;
      offer(1'b1, 32'hDEAD_BEEF, 5'd3, 1'b1, 32'h100);
      tick();
      checks++;
      if (mem_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", mem_valid_out); end
      checks++;
      if ({mem_rd_data_out, mem_rd_addr_out, mem_rd_wr_out, mem_pc_out} !== '0) begin
         failures++; $display("FAIL reset_mem_zero data=%h addr=%h pc=%h exp=0", mem_rd_data_out, mem_rd_addr_out, mem_pc_out);
      end
      checks++;
      if (exe_ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", exe_ready_out); end
      checks++;
      if (fwd_hit_out !== 1'b0) begin failures++; $display("FAIL reset_fwd got=%b exp=0", fwd_hit_out); end
      reset_in = 1'b0;
      offer(1'b0, '0, '0, 1'b0, '0);
   endtask

   task automatic test_stream();
      do_reset();
      mem_ready_in = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         offer(1'b1, 32'h11 * k, 5'(k), 1'b1, 32'h1000 + 4 * k);
         tick();
         checks++;
         if (mem_valid_out !== 1'b1 || mem_rd_data_out !== 32'h11 * k || mem_rd_addr_out !== 5'(k)
             || mem_pc_out !== 32'h1000 + 4 * k) begin
            failures++;
            $display("FAIL stream_%0d valid=%b data=%h rd=%0d pc=%h exp data=%h rd=%0d", k,
                     mem_valid_out, mem_rd_data_out, mem_rd_addr_out, mem_pc_out, 32'h11 * k, k);
         end
         checks++;
         if (exe_ready_out !== 1'b1) begin failures++; $display("FAIL stream_ready_%0d got=%b exp=1", k, exe_ready_out); end
      end
      offer(1'b0, '0, '0, 1'b0, '0);
      tick();
      checks++;
      if (mem_valid_out !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", mem_valid_out); end
   endtask

   task automatic test_backpressure();
      logic [RSZ-1:0] exp_d [6];
      logic           exp_r [6];
      exp_d = '{32'h11, 32'h11, 32'h11, 32'h22, 32'h33, 32'h0};
      exp_r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      do_reset();
      mem_ready_in = 1'b0;
      for (int s = 0; s < 6; s++) begin
         if (s == 0) offer(1'b1, 32'h11, 5'd1, 1'b1, 32'h20);
         if (s == 1) offer(1'b1, 32'h22, 5'd2, 1'b1, 32'h24);
         if (s == 2) offer(1'b1, 32'h33, 5'd3, 1'b1, 32'h28);
         if (s == 3) mem_ready_in = 1'b1;
         if (s == 5) offer(1'b0, '0, '0, 1'b0, '0);
         tick();
         checks++;
         if (mem_rd_data_out !== exp_d[s] || exe_ready_out !== exp_r[s] || mem_valid_out !== (s != 5)) begin
            failures++;
            $display("FAIL bp_step%0d data=%h ready=%b valid=%b exp data=%h ready=%b valid=%b", s,
                     mem_rd_data_out, exe_ready_out, mem_valid_out, exp_d[s], exp_r[s], s != 5);
         end
      end
   endtask

   task automatic test_forward();
      do_reset();
      mem_ready_in = 1'b0;
      offer(1'b1, 32'h9, 5'd9, 1'b1, '0);
      fwd_addr_in = 5'd9;
      #1;
      checks++;
      if (fwd_hit_out !== 1'b0) begin failures++; $display("FAIL fwd_inflight got=%b exp=0", fwd_hit_out); end
      offer(1'b1, 32'hA, 5'd5, 1'b1, '0);
      tick();
      offer(1'b1, 32'hB, 5'd5, 1'b1, '0);
      tick();
      offer(1'b0, '0, '0, 1'b0, '0);
      fwd_addr_in = 5'd5;
      #1;
      checks++;
      if (fwd_hit_out !== 1'b1 || fwd_data_out !== 32'hB) begin
         failures++; $display("FAIL fwd_skid_prio hit=%b data=%h exp hit=1 data=0000000b", fwd_hit_out, fwd_data_out);
      end
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      offer(1'b1, 32'hC, 5'd0, 1'b1, '0);
      tick();
      offer(1'b1, 32'hD, 5'd0, 1'b1, '0);
      tick();
      offer(1'b0, '0, '0, 1'b0, '0);
      fwd_addr_in = 5'd0;
      #1;
      checks++;
      if (fwd_hit_out !== 1'b0 || fwd_data_out !== 32'h0) begin
         failures++; $display("FAIL fwd_x0 hit=%b data=%h exp hit=0 data=0", fwd_hit_out, fwd_data_out);
      end
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      offer(1'b1, 32'hE, 5'd7, 1'b0, '0);
      tick();
      offer(1'b0, '0, '0, 1'b0, '0);
      fwd_addr_in = 5'd7;
      #1;
      checks++;
      if (fwd_hit_out !== 1'b0 || fwd_data_out !== 32'h0) begin
         failures++; $display("FAIL fwd_nowr hit=%b data=%h exp hit=0 data=0", fwd_hit_out, fwd_data_out);
      end
   endtask

   task automatic test_flush();
      do_reset();
      mem_ready_in = 1'b0;
      offer(1'b1, 32'hAA, 5'd1, 1'b1, '0);
      tick();
      offer(1'b1, 32'hBB, 5'd2, 1'b1, '0);
      tick();
      offer(1'b1, 32'hCC, 5'd3, 1'b1, '0);
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      checks++;
      if (mem_valid_out !== 1'b0 || exe_ready_out !== 1'b1) begin
         failures++; $display("FAIL flush_two valid=%b ready=%b exp valid=0 ready=1", mem_valid_out, exe_ready_out);
      end
      offer(1'b0, '0, '0, 1'b0, '0);
      mem_ready_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (mem_valid_out !== 1'b0) begin failures++; $display("FAIL flush_ghost_%0d data=%h exp no entry", i, mem_rd_data_out); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      mem_ready_in = 1'b0;
      offer(1'b1, 32'h55, 5'd4, 1'b1, 32'h40);
      tick();
      offer(1'b0, '0, '0, 1'b0, '0);
      reset_in = 1'b1;
      tick();
      reset_in = 1'b0;
      checks++;
      if (mem_valid_out !== 1'b0 || mem_rd_data_out !== 32'h0 || exe_ready_out !== 1'b1) begin
         failures++; $display("FAIL reset_mid valid=%b data=%h ready=%b exp 0,0,1", mem_valid_out, mem_rd_data_out, exe_ready_out);
      end
   endtask

   task automatic test_random();
      ent_t           h;
      logic [RSZ:0]   f;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         reset_in     = ($urandom_range(0, 149) == 0);
         flush_in     = ($urandom_range(0, 39) == 0);
         mem_ready_in = ($urandom_range(0, 2) != 0);
         offer($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom);
         tick();
         fwd_addr_in = 5'($urandom_range(0, 7));
         #1;
         h = model_head();
         f = model_fwd(fwd_addr_in);
         checks++;
         if (mem_valid_out !== (q.size() > 0) || exe_ready_out !== (q.size() < 2)) begin
            failures++; $display("FAIL rnd_ctl cyc=%0d valid=%b ready=%b exp valid=%b ready=%b", i,
                                 mem_valid_out, exe_ready_out, q.size() > 0, q.size() < 2);
         end
         checks++;
         if ({mem_rd_data_out, mem_rd_addr_out, mem_rd_wr_out, mem_pc_out} !== h) begin
            failures++; $display("FAIL rnd_head cyc=%0d data=%h rd=%0d wr=%b pc=%h exp data=%h rd=%0d wr=%b pc=%h", i,
                                 mem_rd_data_out, mem_rd_addr_out, mem_rd_wr_out, mem_pc_out, h.d, h.a, h.w, h.pc);
         end
         checks++;
         if ({fwd_hit_out, fwd_data_out} !== f) begin
            failures++; $display("FAIL rnd_fwd cyc=%0d addr=%0d hit=%b data=%h exp hit=%b data=%h", i,
                                 fwd_addr_in, fwd_hit_out, fwd_data_out, f[RSZ], f[RSZ-1:0]);
         end
`ifdef EXE_MEM_STALL_CNT_EN
         checks++;
         if (stall_cnt_out !== stall_m) begin
            failures++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", i, stall_cnt_out, stall_m);
         end
`endif
      end
      reset_in = 1'b0;
      flush_in = 1'b0;
   endtask

`ifdef EXE_MEM_STALL_CNT_EN
   task automatic test_stall_cnt();
      do_reset();
      mem_ready_in = 1'b0;
      offer(1'b1, 32'h77, 5'd6, 1'b1, '0);
      tick();
      offer(1'b0, '0, '0, 1'b0, '0);
      repeat (7) tick();
      checks++;
      if (stall_cnt_out !== 32'd7) begin failures++; $display("FAIL stall_7 got=%0d exp=7", stall_cnt_out); end
      flush_in = 1'b1;
      mem_ready_in = 1'b1;
      tick();
      flush_in = 1'b0;
      tick();
      checks++;
      if (stall_cnt_out !== 32'd7) begin failures++; $display("FAIL stall_flush got=%0d exp=7", stall_cnt_out); end
   endtask
`endif

   initial begin
      reset_in = 1'b1;
      flush_in = 1'b0;
      mem_ready_in = 1'b0;
      fwd_addr_in = '0;
      offer(1'b0, '0, '0, 1'b0, '0);
      test_reset();
      test_stream();
      test_backpressure();
      test_forward();
      test_flush();
      test_reset_mid();
`ifdef EXE_MEM_STALL_CNT_EN
      test_stall_cnt();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
